// File: rtl/spi_master_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_driver_if
// Purpose  : Host request/response signals and SPI pins of the frame generator.
// Revision : 1.0
// ============================================================================
interface spi_master_driver_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;

    modport master (
        input  start, cmd, wdata, MISO,
        output busy, done, rd_data, rd_valid, MOSI, SS_n
    );

    modport slave (
        output start, cmd, wdata, MISO,
        input  busy, done, rd_data, rd_valid, MOSI, SS_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_driver.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_driver
// Purpose  : SPI frame generator: SS_n-framed command + byte on MOSI, optional
//            8-bit MISO reply for read-data commands.
// Revision : 1.0
// ============================================================================
module spi_master_driver #(
    parameter int RD_LAT = 1
) (
    input wire                   clk,
    input wire                   rst,
    spi_master_driver_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CMD    = 3'd2,
        S_DATA   = 3'd3,
        S_WAIT   = 3'd4,
        S_RECV   = 3'd5,
        S_END    = 3'd6
    } state_t;

    localparam logic [3:0] c_cmd_last  = 4'd2;
    localparam logic [3:0] c_byte_last = 4'd7;
    localparam logic [3:0] c_wait_last = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
    localparam bit         c_has_wait  = (RD_LAT > 0);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_cmd;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic       r_mosi;
    logic       r_ss_n;
    logic       r_busy;
    logic       r_done;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;

    logic       w_cnt_zero;
    logic [2:0] w_bit_idx;
    logic [7:0] w_shift_in;
    logic       w_is_read;

    assign w_cnt_zero = (r_cnt == 4'd0);
    assign w_bit_idx  = r_cnt[2:0] - 3'd1;
    assign w_shift_in = {r_shift[6:0], bus.MISO};
    assign w_is_read  = (r_cmd == 2'b11);

    // Outputs are registered for the state being entered, so each pin value
    // appears during the cycle that state occupies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_cmd      <= 2'b00;
            r_wdata    <= 8'h00;
            r_shift    <= 8'h00;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ss_n <= 1'b1;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_cmd   <= bus.cmd;
                        r_wdata <= bus.wdata;
                        r_state <= S_SELECT;
                        r_ss_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SELECT: begin
                    r_state <= S_CMD;
                    r_cnt   <= c_cmd_last;
                    r_mosi  <= r_cmd[1];
                end
                S_CMD: begin
                    // Command phase sends cmd[1] twice: the slave's R/W bit then the 2-bit opcode.
                    if (w_cnt_zero) begin
                        r_state <= S_DATA;
                        r_cnt   <= c_byte_last;
                        r_mosi  <= r_wdata[7];
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_mosi  <= (r_cnt == 4'd1) ? r_cmd[0] : r_cmd[1];
                    end
                end
                S_DATA: begin
                    if (w_cnt_zero) begin
                        r_mosi <= 1'b0;
                        if (!w_is_read) begin
                            r_state <= S_END;
                            r_ss_n  <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (c_has_wait) begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_wait_last;
                        end else begin
                            r_state <= S_RECV;
                            r_cnt   <= c_byte_last;
                        end
                    end else begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_mosi <= r_wdata[w_bit_idx];
                    end
                end
                S_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= S_RECV;
                        r_cnt   <= c_byte_last;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                S_RECV: begin
                    r_shift <= w_shift_in;
                    if (w_cnt_zero) begin
                        r_state    <= S_END;
                        r_ss_n     <= 1'b1;
                        r_done     <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_shift_in;
                    end else begin
                        r_cnt      <= r_cnt - 4'd1;
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MOSI     = r_mosi;
    assign bus.SS_n     = r_ss_n;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule
`default_nettype wire
